board_predict_sequencer: RTL and testbench

- Downstream controller wrapped around the digit predictor; walks all 81 Sudoku cells in raster order.
- Per cell:
  - fetches the 52x52 binary cell image from the cell-image provider;
  - counts set pixels serially;
  - skips near-empty cells (digit 0), otherwise starts the predictor and collects its 4-bit result.
- Assembles an 81x4-bit board vector for the solver/display stage.

---
 rtl/board_predict_sequencer_if.sv | 52 +++++
 rtl/board_predict_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_board_predict_sequencer.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_predict_sequencer_if.sv
// Cell-provider, predictor and board-result signals of the board sequencer.
// master = sequencer side, slave = environment side.
interface board_predict_sequencer_if #(
  parameter int CELLS = 81,
  parameter int IMG_W = 52
);
  logic                   start;
  logic                   cell_req;
  logic [6:0]             cell_idx;
  logic                   cell_valid;
  logic [IMG_W*IMG_W-1:0] cell_img;
  logic                   pred_start;
  logic [IMG_W*IMG_W-1:0] pred_track_input;
  logic [3:0]             pred_number;
  logic                   pred_finish;
  logic [CELLS*4-1:0]     board;
  logic                   busy;
  logic                   done;
  logic                   timeout_err;

  modport master (
    input  start,
    input  cell_valid,
    input  cell_img,
    input  pred_number,
    input  pred_finish,
    output cell_req,
    output cell_idx,
    output pred_start,
    output pred_track_input,
    output board,
    output busy,
    output done,
    output timeout_err
  );

  modport slave (
    output start,
    output cell_valid,
    output cell_img,
    output pred_number,
    output pred_finish,
    input  cell_req,
    input  cell_idx,
    input  pred_start,
    input  pred_track_input,
    input  board,
    input  busy,
    input  done,
    input  timeout_err
  );
endinterface

// File: rtl/board_predict_sequencer.sv
// Walks all board cells: fetch image, count pixels, run predictor, build board.
// Optional predictor watchdog: define BOARD_PRED_TIMEOUT_EN.
module board_predict_sequencer #(
  parameter int CELLS        = 81,
  parameter int IMG_W        = 52,
  parameter int BLANK_THRESH = 40,
  parameter int TIMEOUT_CYC  = 4096
) (
  input logic clk,
  input logic rst_n,
  board_predict_sequencer_if.master bus
);
  localparam int NPIX = IMG_W * IMG_W;
  localparam int RW   = $clog2(IMG_W);
  localparam int PW   = $clog2(IMG_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    COUNT,
    PRED,
    WAIT_PRED,
    STORE,
    DONE
  } state_t;

  state_t             state;
  logic               cell_req;
  logic               pred_start;
  logic               busy;
  logic               done;
  logic               timeout_err;
  logic [6:0]         cell_idx;
  logic [NPIX-1:0]    img;
  logic [CELLS*4-1:0] board;
  logic [11:0]        pix_cnt;
  logic [RW-1:0]      row_cnt;
  logic [3:0]         digit;

  logic [IMG_W-1:0]   row;
  logic [11:0]        pix_next;
  logic [3:0]         pred_dig;
  logic               last_row;
  logic               last_cell;

  function automatic logic [PW-1:0] popcnt(
    input logic [IMG_W-1:0] v
  );
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < IMG_W; i++) begin
      c = c + PW'(v[i]);
    end
    return c;
  endfunction

  always_comb begin
    row       = img[int'(row_cnt)*IMG_W +: IMG_W];
    pix_next  = pix_cnt + 12'(popcnt(row));
    last_row  = (row_cnt == RW'(IMG_W - 1));
    last_cell = (cell_idx == 7'(CELLS - 1));
    pred_dig  = 4'd0;
    if (bus.pred_number >= 4'd1 &&
        bus.pred_number <= 4'd9) begin
      pred_dig = bus.pred_number;
    end
  end

`ifdef BOARD_PRED_TIMEOUT_EN
  logic [12:0] wd;
  logic        wd_hit;

  assign wd_hit = (wd == 13'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cyc;

  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cell_req   <= 1'b0;
      pred_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cell_idx   <= '0;
      img        <= '0;
      board      <= '0;
      pix_cnt    <= '0;
      row_cnt    <= '0;
      digit      <= '0;
`ifdef BOARD_PRED_TIMEOUT_EN
      wd          <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= REQ;
            board    <= '0;
            cell_idx <= '0;
            cell_req <= 1'b1;
            busy     <= 1'b1;
`ifdef BOARD_PRED_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
          end
        end
        REQ: begin
          if (bus.cell_valid) begin
            img      <= bus.cell_img;
            pix_cnt  <= '0;
            row_cnt  <= '0;
            cell_req <= 1'b0;
            state    <= COUNT;
          end
        end
        COUNT: begin
          pix_cnt <= pix_next;
          if (last_row) begin
            row_cnt <= '0;
            if (pix_next < 12'(BLANK_THRESH)) begin
              digit <= 4'd0;
              state <= STORE;
            end else begin
              pred_start <= 1'b1;
              state      <= PRED;
            end
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        PRED: begin
          pred_start <= 1'b0;
          state      <= WAIT_PRED;
`ifdef BOARD_PRED_TIMEOUT_EN
          wd <= '0;
`endif
        end
        WAIT_PRED: begin
`ifdef BOARD_PRED_TIMEOUT_EN
          wd <= wd + 1'b1;
          // a finish on the limit cycle still delivers its result
          if (bus.pred_finish) begin
            digit <= pred_dig;
            state <= STORE;
          end else if (wd_hit) begin
            digit       <= 4'd0;
            timeout_err <= 1'b1;
            state       <= STORE;
          end
`else
          if (bus.pred_finish) begin
            digit <= pred_dig;
            state <= STORE;
          end
`endif
        end
        STORE: begin
          board[int'(cell_idx)*4 +: 4] <= digit;
          if (last_cell) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cell_idx <= cell_idx + 1'b1;
            cell_req <= 1'b1;
            state    <= REQ;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cell_req         = cell_req;
  assign bus.cell_idx         = cell_idx;
  assign bus.pred_start       = pred_start;
  assign bus.pred_track_input = img;
  assign bus.board            = board;
  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.timeout_err      = timeout_err;
endmodule

// File: tb/tb_board_predict_sequencer.sv
// Bench for board_predict_sequencer: random cell images and predictor
// behaviour checked against a per-cell reference model.
module tb_board_predict_sequencer;
  localparam int CELLS = 81;
  localparam int IMG_W = 52;
  localparam int NPIX  = IMG_W * IMG_W;
  localparam int THR   = 40;
  localparam int TO    = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  board_predict_sequencer_if #(
    .CELLS(CELLS),
    .IMG_W(IMG_W)
  ) bus ();

  board_predict_sequencer #(
    .CELLS(CELLS),
    .IMG_W(IMG_W),
    .BLANK_THRESH(THR),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [NPIX-1:0] imgs [CELLS];
  int pop_n  [CELLS];
  int pred_v [CELLS];
  int pred_l [CELLS];
  int req_d  [CELLS];
  bit spur   [CELLS];

  // cell-image provider: answers after req_d[idx] extra REQ cycles
  int seen;
  initial begin
    bus.cell_valid = 1'b0;
    bus.cell_img = '0;
    seen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.cell_valid = 1'b0;
        seen = 0;
      end else if (bus.cell_valid) begin
        bus.cell_valid = 1'b0;
        bus.cell_img = {NPIX{1'b1}};
        seen = 0;
      end else if (bus.cell_req) begin
        if (seen == req_d[bus.cell_idx]) begin
          bus.cell_img = imgs[bus.cell_idx];
          bus.cell_valid = 1'b1;
        end else begin
          seen++;
        end
      end
    end
  end

  // predictor: finish pred_l cycles into WAIT_PRED; 0 = never answers
  int pcnt;
  int pcur;
  initial begin
    bus.pred_finish = 1'b0;
    bus.pred_number = 4'd0;
    pcnt = 0;
    pcur = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.pred_finish = 1'b0;
      if (!rst_n) begin
        pcnt = 0;
      end else begin
        if (pcnt > 0) begin
          pcnt--;
          if (pcnt == 0) begin
            bus.pred_finish = 1'b1;
            bus.pred_number = 4'(pred_v[pcur]);
          end
        end
        if (bus.pred_start) begin
          pcur = int'(bus.cell_idx);
          pcnt = pred_l[pcur];
          if (spur[pcur]) begin
            bus.pred_finish = 1'b1;
            bus.pred_number = 4'd3;
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic make_img(input int k, input int n);
    logic [NPIX-1:0] v;
    int c;
    int p;
    v = '0;
    c = 0;
    while (c < n) begin
      p = $urandom_range(NPIX - 1, 0);
      if (!v[p]) begin
        v[p] = 1'b1;
        c++;
      end
    end
    imgs[k] = v;
  endtask

  task automatic build_imgs();
    for (int k = 0; k < CELLS; k++) make_img(k, pop_n[k]);
  endtask

  function automatic bit nonblank(int k);
    return $countones(imgs[k]) >= THR;
  endfunction

  function automatic int exp_digit(int k);
    if (!nonblank(k)) return 0;
    if (pred_l[k] == 0) return 0;
    if (pred_v[k] >= 1 && pred_v[k] <= 9) return pred_v[k];
    return 0;
  endfunction

  function automatic logic [CELLS*4-1:0] exp_board();
    logic [CELLS*4-1:0] b;
    b = '0;
    for (int k = 0; k < CELLS; k++) b[k*4 +: 4] = 4'(exp_digit(k));
    return b;
  endfunction

  function automatic int exp_cycles();
    int t;
    t = 0;
    for (int k = 0; k < CELLS; k++) begin
      t += req_d[k] + 1 + IMG_W + 1;
      if (nonblank(k)) t += 1 + ((pred_l[k] == 0) ? TO : pred_l[k]);
    end
    return t;
  endfunction

  function automatic int exp_starts();
    int n;
    n = 0;
    for (int k = 0; k < CELLS; k++) if (nonblank(k)) n++;
    return n;
  endfunction

  // drives one pass; returns observations only
  task automatic run_pass(
    input  int         inject,
    output int         cyc,
    output int         ps,
    output int         dn,
    output int         bad,
    output logic       busy_after,
    output logic [6:0] first_idx,
    output logic       first_req,
    output logic       first_terr
  );
    int lim;
    lim = exp_cycles() + 100;
    ps = 0;
    dn = 0;
    bad = 0;
    cyc = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    first_idx = bus.cell_idx;
    first_req = bus.cell_req;
    first_terr = bus.timeout_err;
    forever begin
      if (bus.pred_start) begin
        ps++;
        if (bus.pred_track_input !== imgs[bus.cell_idx]) bad++;
      end
      if (bus.done) begin
        dn++;
        break;
      end
      if (cyc >= lim) break;
      @(negedge clk);
      cyc++;
      bus.start = (inject != 0 && cyc == inject);
    end
    bus.start = 1'b0;
    @(negedge clk);
    busy_after = bus.busy;
    if (bus.done) dn++;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
  endtask

  task automatic set_uniform(input int pop, input int lat, input int dly);
    for (int k = 0; k < CELLS; k++) begin
      pop_n[k] = pop;
      pred_v[k] = (k % 9) + 1;
      pred_l[k] = lat;
      req_d[k] = dly;
      spur[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.done, bus.cell_req, bus.pred_start,
         bus.timeout_err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got %b want 00000",
               {bus.busy, bus.done, bus.cell_req, bus.pred_start,
                bus.timeout_err});
    end
    tests_run++;
    if (bus.board !== '0) begin
      tests_failed++;
      $display("FAIL reset_board got %h want 0", bus.board);
    end
    tests_run++;
    if (bus.cell_idx !== 7'd0 || bus.pred_track_input !== '0) begin
      tests_failed++;
      $display("FAIL reset_idx_img idx %0d want 0", bus.cell_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_blank_board();
    int cyc, ps, dn, bad;
    logic ba, fr, ft;
    logic [6:0] fi;
    set_uniform(0, 10, 1);
    build_imgs();
    run_pass(0, cyc, ps, dn, bad, ba, fi, fr, ft);
    tests_run++;
    if (cyc !== 4455) begin
      tests_failed++;
      $display("FAIL blank_cycles got %0d want 4455", cyc);
    end
    tests_run++;
    if (ps !== 0) begin
      tests_failed++;
      $display("FAIL blank_pred_start got %0d want 0", ps);
    end
    tests_run++;
    if (bus.board !== '0 || dn !== 1) begin
      tests_failed++;
      $display("FAIL blank_board done %0d want 1 board %h", dn, bus.board);
    end
  endtask

  task automatic test_threshold();
    int cyc, ps, dn, bad;
    logic ba, fr, ft;
    logic [6:0] fi;
    set_uniform(0, 5, 1);
    pop_n[0] = 39;
    pop_n[1] = 40;
    for (int k = 0; k < CELLS; k++) pred_v[k] = 7;
    build_imgs();
    run_pass(0, cyc, ps, dn, bad, ba, fi, fr, ft);
    tests_run++;
    if (bus.board[3:0] !== 4'd0 || bus.board[7:4] !== 4'd7) begin
      tests_failed++;
      $display("FAIL thresh_cells got %0d,%0d want 0,7",
               bus.board[3:0], bus.board[7:4]);
    end
    tests_run++;
    if (ps !== 1 || bad !== 0) begin
      tests_failed++;
      $display("FAIL thresh_pred_start got %0d bad %0d want 1 bad 0",
               ps, bad);
    end
    tests_run++;
    if (cyc !== exp_cycles()) begin
      tests_failed++;
      $display("FAIL thresh_cycles got %0d want %0d", cyc, exp_cycles());
    end
  endtask

  task automatic test_dense();
    int cyc, ps, dn, bad;
    logic ba, fr, ft;
    logic [6:0] fi;
    set_uniform(0, 10, 0);
    for (int k = 0; k < CELLS; k++) begin
      pop_n[k] = $urandom_range(400, 40);
      req_d[k] = $urandom_range(3, 0);
    end
    pred_v[5] = 12;
    pred_v[6] = 0;
    spur[7] = 1'b1;
    build_imgs();
    run_pass(1000, cyc, ps, dn, bad, ba, fi, fr, ft);
    for (int k = 0; k < CELLS; k++) begin
      tests_run++;
      if (bus.board[k*4 +: 4] !== 4'(exp_digit(k))) begin
        tests_failed++;
        $display("FAIL dense_cell%0d got %0d want %0d",
                 k, bus.board[k*4 +: 4], exp_digit(k));
      end
    end
    tests_run++;
    if (bus.board[23:20] !== 4'd0) begin
      tests_failed++;
      $display("FAIL dense_cell5_range got %0d want 0", bus.board[23:20]);
    end
    tests_run++;
    if (cyc !== exp_cycles()) begin
      tests_failed++;
      $display("FAIL dense_cycles got %0d want %0d", cyc, exp_cycles());
    end
    tests_run++;
    if (ps !== 81 || bad !== 0) begin
      tests_failed++;
      $display("FAIL dense_pred got %0d bad %0d want 81 bad 0", ps, bad);
    end
    tests_run++;
    if (dn !== 1 || ba !== 1'b0) begin
      tests_failed++;
      $display("FAIL dense_done done %0d busy %b want 1 0", dn, ba);
    end
    tests_run++;
    if (bus.timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL dense_terr got %b want 0", bus.timeout_err);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, ps, dn, bad;
    logic ba, fr, ft;
    logic [6:0] fi;
    for (int it = 0; it < 2; it++) begin
      for (int k = 0; k < CELLS; k++) begin
        pop_n[k] = $urandom_range(80, 0);
        pred_v[k] = $urandom_range(15, 0);
        pred_l[k] = $urandom_range(20, 1);
        req_d[k] = $urandom_range(4, 0);
        spur[k] = ($urandom_range(7, 0) == 0);
      end
      build_imgs();
      run_pass(0, cyc, ps, dn, bad, ba, fi, fr, ft);
      tests_run++;
      if (bus.board !== exp_board()) begin
        tests_failed++;
        $display("FAIL rand%0d_board got %h want %h",
                 it, bus.board, exp_board());
      end
      tests_run++;
      if (cyc !== exp_cycles()) begin
        tests_failed++;
        $display("FAIL rand%0d_cycles got %0d want %0d",
                 it, cyc, exp_cycles());
      end
      tests_run++;
      if (ps !== exp_starts() || bad !== 0 || dn !== 1) begin
        tests_failed++;
        $display("FAIL rand%0d_pred got %0d/%0d/%0d want %0d/0/1",
                 it, ps, bad, dn, exp_starts());
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, ps, dn, bad, n;
    logic ba, fr, ft;
    logic [6:0] fi;
    set_uniform(100, 10, 1);
    build_imgs();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!(bus.pred_start && bus.cell_idx == 7'd40) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n >= 20000) begin
      tests_failed++;
      $display("FAIL mid_reach_cell40 got no pred_start want one");
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.board[3:0] !== 4'd1) begin
      tests_failed++;
      $display("FAIL mid_pre_reset_cell0 got %0d want 1", bus.board[3:0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.cell_req !== 1'b0 ||
        bus.board !== '0 || bus.cell_idx !== 7'd0) begin
      tests_failed++;
      $display("FAIL mid_reset busy %b req %b idx %0d want 0 0 0 board 0",
               bus.busy, bus.cell_req, bus.cell_idx);
    end
    rst_n = 1'b1;
    run_pass(0, cyc, ps, dn, bad, ba, fi, fr, ft);
    tests_run++;
    if (fi !== 7'd0 || fr !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_restart idx %0d req %b want 0 1", fi, fr);
    end
    tests_run++;
    if (bus.board !== exp_board() || cyc !== exp_cycles()) begin
      tests_failed++;
      $display("FAIL mid_rerun cycles %0d want %0d", cyc, exp_cycles());
    end
  endtask

`ifdef BOARD_PRED_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, ps, dn, bad;
    logic ba, fr, ft;
    logic [6:0] fi;
    set_uniform(60, 3, 0);
    pred_l[3] = 0;
    build_imgs();
    run_pass(0, cyc, ps, dn, bad, ba, fi, fr, ft);
    tests_run++;
    if (bus.timeout_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_flag got %b want 1", bus.timeout_err);
    end
    tests_run++;
    if (bus.board !== exp_board() || bus.board[15:12] !== 4'd0) begin
      tests_failed++;
      $display("FAIL timeout_board got %h want %h", bus.board, exp_board());
    end
    tests_run++;
    if (cyc !== exp_cycles()) begin
      tests_failed++;
      $display("FAIL timeout_cycles got %0d want %0d", cyc, exp_cycles());
    end
    pred_l[3] = 3;
    run_pass(0, cyc, ps, dn, bad, ba, fi, fr, ft);
    tests_run++;
    if (ft !== 1'b0 || bus.timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_clear got %b/%b want 0/0",
               ft, bus.timeout_err);
    end
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_blank_board();
    test_threshold();
    test_dense();
    test_back_to_back();
    test_reset_mid();
`ifdef BOARD_PRED_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
